mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port byte-addressed data/instruction RAM.
- Port 0 is instruction fetch and port 1 is load/store. The block shares the RAM between them with round-robin arbitration.
- Each granted request is driven into the RAM for exactly one cycle; the read word is returned registered.
- Out-of-range and misaligned accesses are rejected with an error flag, and their writes are suppressed.

Parameters:
- NUM_OF_BYTES, 800, RAM size in bytes. A word access is legal only if addr < NUM_OF_BYTES-3.
- ALIGN_CHECK, 1, when 1, addr[1:0] != 0 is an error; when 0, unaligned addresses pass through.

Ports:
- clk  input  1  system clock, all state updates on posedge
- rst_n  input  1  asynchronous active-low reset
- m0_req  input  1  port 0 request, sampled only in IDLE
- m0_addr  input  32  port 0 byte address
- m0_we  input  1  port 0 write enable
- m0_wdata  input  32  port 0 write word
- m0_gnt  output  1  port 0 granted (ACCESS cycle)
- m0_rvalid  output  1  port 0 response valid (RESP cycle)
- m0_rdata  output  32  port 0 read word
- m0_err  output  1  port 0 access error, valid with m0_rvalid
- m1_req, m1_addr, m1_we, m1_wdata, m1_gnt, m1_rvalid, m1_rdata, m1_err  same directions, widths and meaning for port 1
- mem_address  output  32  RAM address
- mem_write_en  output  1  RAM write enable (RAM writes on posedge clk)
- mem_write_data  output  32  RAM write word
- mem_read_data  input  32  RAM combinational read word

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, last_grant=1, all outputs 0, latched address/data/we/err 0. A write in flight is aborted because mem_write_en drops immediately.
- FSM has three states and never stalls:
  - IDLE -> ACCESS when any req is high.
  - ACCESS -> RESP unconditionally.
  - RESP -> IDLE unconditionally.
- One access every 3 cycles, with fixed latency of 2 cycles from the sampling edge to rvalid.
- Arbitration in IDLE:
  - Only m0_req: port 0 wins. Only m1_req: port 1 wins.
  - Both requesting: the port != last_grant wins.
  - At the IDLE->ACCESS edge, latch winner, addr, we, wdata, and err, and update last_grant to the winner.
- err = (addr >= NUM_OF_BYTES-3) | (ALIGN_CHECK & (addr[1:0] != 0)). Unsigned 32-bit compare.
- ACCESS cycle:
  - mX_gnt=1 for the winner only.
  - mem_address = latched addr.
  - mem_write_data = latched wdata.
  - mem_write_en = latched we & ~err.
  - At the end-of-cycle edge, rdata_reg <= (we | err) ? 0 : mem_read_data.
- RESP cycle:
  - Winner's mX_rvalid=1, mX_rdata=rdata_reg, mX_err=latched err.
  - The loser's rvalid, rdata and err are 0.
- Outside ACCESS: mem_address=0, mem_write_en=0, mem_write_data=0.
- Outside RESP: all rvalid=0, rdata=0, err=0.
- All gnt/rvalid are single-cycle pulses. gnt and rvalid are never high in the same cycle.
- Requester protocol:
  - Hold req/addr/we/wdata stable until gnt is seen.
  - The request is captured at the IDLE edge, so changes after that edge have no effect on the current access.
  - A req still high in the next IDLE is treated as a new request.
- Simultaneous events:
  - A req rising during ACCESS/RESP waits for IDLE.
  - Both ports continuously requesting strictly alternate 0,1,0,1...
- Write followed by read at the same address returns the new data; the RAM write is complete before the next ACCESS.
- Reset asserted in ACCESS or RESP: no rvalid is produced, and the requester must reissue.

Test Plan:
- Reset release; m0_req=1, m0_addr=0x10, m0_we=1, m0_wdata=0xDEADBEEF. Expected: m0_gnt at cycle 2 with mem_write_en=1, mem_address=0x10; m0_rvalid at cycle 3 with rdata=0, err=0.
- Then m1 reads 0x10. Expected: m1_rvalid with m1_rdata=0xDEADBEEF and err=0; m0 outputs stay 0.
- Both req held high for 4 accesses starting after reset. Expected: grant order 0,1,0,1; each rvalid exactly 2 cycles after its IDLE sample; 3-cycle spacing between grants.
- m0 accesses addr=797 (NUM_OF_BYTES-3) as a write, and addr=0x11 with ALIGN_CHECK=1. Expected: mem_write_en stays 0, m0_err=1, m0_rdata=0; RAM contents unchanged on readback.
- Assert rst_n=0 mid-ACCESS of a write. Expected: mem_write_en drops asynchronously, no rvalid, state IDLE, and the next tie grants port 0.
- m1 issues a single read at 0x20 while m0 is idle. Expected: port 1 is granted immediately (no round-robin penalty), then last_grant=1 so the next tie goes to port 0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bus bundle between the two requesters, the arbiter and the RAM
// Ports: m0_*/m1_* request/response channels, mem_* single-port RAM channel
// Modports: slave = arbiter side, master = requester/RAM side
interface mem_arbiter_if;
    logic        m0_req;
    logic [31:0] m0_addr;
    logic        m0_we;
    logic [31:0] m0_wdata;
    logic        m0_gnt;
    logic        m0_rvalid;
    logic [31:0] m0_rdata;
    logic        m0_err;
    logic        m1_req;
    logic [31:0] m1_addr;
    logic        m1_we;
    logic [31:0] m1_wdata;
    logic        m1_gnt;
    logic        m1_rvalid;
    logic [31:0] m1_rdata;
    logic        m1_err;
    logic [31:0] mem_address;
    logic        mem_write_en;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport slave (
        input  m0_req, m0_addr, m0_we, m0_wdata, m1_req, m1_addr, m1_we, m1_wdata, mem_read_data,
        output m0_gnt, m0_rvalid, m0_rdata, m0_err, m1_gnt, m1_rvalid, m1_rdata, m1_err,
        output mem_address, mem_write_en, mem_write_data
    );

    modport master (
        output m0_req, m0_addr, m0_we, m0_wdata, m1_req, m1_addr, m1_we, m1_wdata, mem_read_data,
        input  m0_gnt, m0_rvalid, m0_rdata, m0_err, m1_gnt, m1_rvalid, m1_rdata, m1_err,
        input  mem_address, mem_write_en, mem_write_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-port arbiter/sequencer in front of a single-port RAM
// Ports: clk, rst_n (async active-low), bus (mem_arbiter_if.slave: m0/m1 request channels, RAM channel)
module mem_arbiter #(
    parameter int NUM_OF_BYTES = 800,
    parameter bit ALIGN_CHECK  = 1'b1
) (
    input logic        clk,
    input logic        rst_n,
    mem_arbiter_if.slave bus
);
    localparam logic [31:0] LIMIT = 32'(NUM_OF_BYTES - 3);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state, state_next;
    logic        last_grant, win, we_q, err_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic        any_req, pick, pick_we, pick_err, acc, rsp;
    logic [31:0] pick_addr, pick_wdata;

    // On a tie the port that was not served last wins; a lone requester always wins.
    always_comb begin
        any_req    = bus.m0_req | bus.m1_req;
        pick       = (bus.m0_req & bus.m1_req) ? ~last_grant : bus.m1_req;
        pick_addr  = pick ? bus.m1_addr : bus.m0_addr;
        pick_we    = pick ? bus.m1_we : bus.m0_we;
        pick_wdata = pick ? bus.m1_wdata : bus.m0_wdata;
        pick_err   = (pick_addr >= LIMIT) | (ALIGN_CHECK & (pick_addr[1:0] != 2'b00));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = (state == IDLE) ? (any_req ? ACCESS : IDLE) :
                     (state == ACCESS) ? RESP : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            win        <= 1'b0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                last_grant <= pick;
                win        <= pick;
                we_q       <= pick_we;
                err_q      <= pick_err;
                addr_q     <= pick_addr;
                wdata_q    <= pick_wdata;
            end
            // Writes and rejected accesses return zero instead of whatever the RAM drives.
            if (state == ACCESS) rdata_q <= (we_q | err_q) ? '0 : bus.mem_read_data;
        end
    end

    // Outputs decode straight from state, so reset clears them without waiting for a clock.
    always_comb begin
        acc                = (state == ACCESS);
        rsp                = (state == RESP);
        bus.m0_gnt         = acc & ~win;
        bus.m1_gnt         = acc & win;
        bus.mem_address    = acc ? addr_q : '0;
        bus.mem_write_data = acc ? wdata_q : '0;
        bus.mem_write_en   = acc & we_q & ~err_q;
        bus.m0_rvalid      = rsp & ~win;
        bus.m1_rvalid      = rsp & win;
        bus.m0_rdata       = (rsp & ~win) ? rdata_q : '0;
        bus.m1_rdata       = (rsp & win) ? rdata_q : '0;
        bus.m0_err         = rsp & ~win & err_q;
        bus.m1_err         = rsp & win & err_q;
    end
endmodule
